// File: rtl/simple_dual_port_ram_pkg.sv
// Shared definitions for simple_dual_port_ram.
//   - Default geometry used by the RAM, its read ports and its interface.
//   - fwd_sel_e: source selected by a read-port output register at a clock
//     edge (array word read before the edge, or this port's own write data).
package simple_dual_port_ram_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 4;
  localparam int unsigned DEFAULT_INDEX_BITS    = 4;

  typedef enum logic {
    SEL_MEM   = 1'b0,  // pre-edge array contents
    SEL_WRITE = 1'b1   // forward this port's write data (write-first)
  } fwd_sel_e;

endpackage

// File: rtl/simple_dual_port_ram_if.sv
// Per-port access bundle of simple_dual_port_ram.
//   writeEnable_n : port n write strobe (1 = write, 0 = read)
//   writeData_n   : port n write data
//   address_n     : port n address (read and write)
//   readData_n    : port n registered read data
// Modports: master drives the accesses, slave is the RAM.
interface simple_dual_port_ram_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 4
);

  logic                     writeEnable_0;
  logic                     writeEnable_1;
  logic [DATA_WIDTH-1:0]    writeData_0;
  logic [DATA_WIDTH-1:0]    writeData_1;
  logic [ADDRESS_WIDTH-1:0] address_0;
  logic [ADDRESS_WIDTH-1:0] address_1;
  logic [DATA_WIDTH-1:0]    readData_0;
  logic [DATA_WIDTH-1:0]    readData_1;

  modport master (
    output writeEnable_0, writeEnable_1,
    output writeData_0, writeData_1,
    output address_0, address_1,
    input  readData_0, readData_1
  );

  modport slave (
    input  writeEnable_0, writeEnable_1,
    input  writeData_0, writeData_1,
    input  address_0, address_1,
    output readData_0, readData_1
  );

endinterface

// File: rtl/simple_dual_port_ram_read_port.sv
// Registered read output of one RAM port.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low, clears read_data
//   sel        : SEL_MEM loads mem_data, SEL_WRITE loads write_data
//   write_data : this port's write data (write-first forwarding)
//   mem_data   : array word at this port's index, before this edge's writes
//   read_data  : registered read data
module simple_dual_port_ram_read_port
  import simple_dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  fwd_sel_e              sel,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] next_data;

  always_comb begin
    next_data = mem_data;
    if (sel == SEL_WRITE) next_data = write_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) read_data <= '0;
    else        read_data <= next_data;
  end

endmodule

// File: rtl/simple_dual_port_ram.sv
// Two-port synchronous RAM, 2^INDEX_BITS words of DATA_WIDTH bits.
//   clock : rising-edge clock for all state
//   reset : asynchronous active-low; clears both read registers and blocks
//           writes while low (array contents are retained, never cleared)
//   bus   : slave side of simple_dual_port_ram_if (both ports' strobes,
//           write data, addresses and registered read data)
// Each port reads or writes once per edge with 1-cycle read latency.
// Own-port write forwards (write-first); a cross-port read of a word being
// written returns the old word. On a same-index double write port 1 wins and
// port 0's write is dropped, so port 0 reads the old word.
// Only address[INDEX_BITS-1:0] indexes the array; INDEX_BITS <= ADDRESS_WIDTH.
module simple_dual_port_ram
  import simple_dual_port_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned INDEX_BITS    = DEFAULT_INDEX_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  simple_dual_port_ram_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

  logic [INDEX_BITS-1:0] index_0;
  logic [INDEX_BITS-1:0] index_1;
  logic                  write_0;
  logic                  write_1;
  logic [DATA_WIDTH-1:0] mem_0;
  logic [DATA_WIDTH-1:0] mem_1;
  fwd_sel_e              sel_0;
  fwd_sel_e              sel_1;

  always_comb begin
    index_0 = bus.address_0[INDEX_BITS-1:0];
    index_1 = bus.address_1[INDEX_BITS-1:0];
    write_1 = bus.writeEnable_1;
    // Port 1 wins a same-index collision: port 0's write is suppressed both
    // in the array and in its own forwarding path.
    write_0 = bus.writeEnable_0 && !(bus.writeEnable_1 && (index_0 == index_1));
    mem_0   = ram[index_0];
    mem_1   = ram[index_1];
    sel_0   = write_0 ? SEL_WRITE : SEL_MEM;
    sel_1   = write_1 ? SEL_WRITE : SEL_MEM;
  end

  // Array has no reset; reset level is sampled only to block writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (write_0) ram[index_0] <= bus.writeData_0;
      if (write_1) ram[index_1] <= bus.writeData_1;
    end
  end

  simple_dual_port_ram_read_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_read_port_0 (
    .clock      (clock),
    .reset      (reset),
    .sel        (sel_0),
    .write_data (bus.writeData_0),
    .mem_data   (mem_0),
    .read_data  (bus.readData_0)
  );

  simple_dual_port_ram_read_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_read_port_1 (
    .clock      (clock),
    .reset      (reset),
    .sel        (sel_1),
    .write_data (bus.writeData_1),
    .mem_data   (mem_1),
    .read_data  (bus.readData_1)
  );

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Self-checking bench for simple_dual_port_ram (8-bit data, 16 words).
module tb_simple_dual_port_ram;

  logic clock;
  logic reset;

  simple_dual_port_ram_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  simple_dual_port_ram #(
    .DATA_WIDTH    (8),
    .ADDRESS_WIDTH (4),
    .INDEX_BITS    (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       we0;
    logic       we1;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] e0;
    logic [7:0] e1;
  } exp_t;

  vec_t vecs [15];
  exp_t sb_q [$];
  int   passed;
  int   total;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic we0, input logic we1, input logic [7:0] wd0,
                       input logic [7:0] wd1, input logic [3:0] a0, input logic [3:0] a1);
    bus.writeEnable_0 = we0;
    bus.writeEnable_1 = we1;
    bus.writeData_0   = wd0;
    bus.writeData_1   = wd1;
    bus.address_0     = a0;
    bus.address_1     = a1;
  endtask

  // Drive on the falling edge, expect after the following rising edge.
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    @(negedge clock);
    drive(v.we0, v.we1, v.wd0, v.wd1, v.a0, v.a1);
    sb_q.push_back('{name, v.e0, v.e1});
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check({name, " scoreboard"}, 8'h01, 8'h00);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " rd0"}, bus.readData_0, e.e0);
      check({e.name, " rd1"}, bus.readData_1, e.e1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           we0   we1   wd0    wd1    a0  a1  e0     e1
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, 5,  0,  8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h49, 8'h00, 14, 0,  8'h49, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h53, 8'h00, 7,  14, 8'h53, 8'h49};
    vecs[3]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 14, 7,  8'h49, 8'h53};
    vecs[4]  = '{1'b1, 1'b1, 8'h11, 8'h22, 7,  7,  8'h53, 8'h22};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 7,  7,  8'h22, 8'h22};
    vecs[6]  = '{1'b1, 1'b1, 8'hA5, 8'h5A, 3,  9,  8'hA5, 8'h5A};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 3,  9,  8'hA5, 8'h5A};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h77, 5,  5,  8'h00, 8'h77};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 5,  14, 8'h77, 8'h49};
    vecs[10] = '{1'b1, 1'b0, 8'h3C, 8'h00, 3,  3,  8'h3C, 8'hA5};
    vecs[11] = '{1'b1, 1'b0, 8'h81, 8'h00, 8,  3,  8'h81, 8'h3C};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 8,  14, 8'h81, 8'h49};
    vecs[13] = '{1'b1, 1'b1, 8'hF0, 8'h0F, 8,  8,  8'h81, 8'h0F};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 8,  8,  8'h0F, 8'h0F};

    passed = 0;
    total  = 0;

    // Reset from time zero with writes toggling: outputs stay zero.
    reset = 1'b0;
    drive(1'b1, 1'b1, 8'hDE, 8'hAD, 4'd14, 4'd7);
    #1;
    check("reset0 rd0", bus.readData_0, 8'h00);
    check("reset0 rd1", bus.readData_1, 8'h00);
    for (int unsigned c = 0; c < 2; c++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, 8'(8'hDE + c), 8'(8'hAD + c), 4'(c), 4'(c + 1));
      @(posedge clock);
      #1;
      check($sformatf("reset cyc%0d rd0", c), bus.readData_0, 8'h00);
      check($sformatf("reset cyc%0d rd1", c), bus.readData_1, 8'h00);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 4'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    check("ram[14]", dut.ram[14], 8'h49);
    check("ram[7]",  dut.ram[7],  8'h22);
    check("ram[3]",  dut.ram[3],  8'h3C);
    check("ram[9]",  dut.ram[9],  8'h5A);
    check("ram[5]",  dut.ram[5],  8'h77);
    check("ram[8]",  dut.ram[8],  8'h0F);

    // Mid-operation reset: outputs clear at once, array retained.
    apply("pre_reset", '{1'b1, 1'b0, 8'hC3, 8'h00, 4'd2, 4'd14, 8'hC3, 8'h49});
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 4'd14);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset rd0", bus.readData_0, 8'h00);
    check("async_reset rd1", bus.readData_1, 8'h00);
    for (int unsigned c = 0; c < 2; c++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, 8'h55, 8'hAA, 4'd2, 4'd14);
      @(posedge clock);
      #1;
      check($sformatf("mid_reset cyc%0d rd0", c), bus.readData_0, 8'h00);
      check($sformatf("mid_reset cyc%0d rd1", c), bus.readData_1, 8'h00);
    end
    check("ram[2] kept",  dut.ram[2],  8'hC3);
    check("ram[14] kept", dut.ram[14], 8'h49);
    @(negedge clock);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 4'd0);
    reset = 1'b1;
    apply("post_reset", '{1'b0, 1'b0, 8'h00, 8'h00, 4'd2, 4'd14, 8'hC3, 8'h49});

    if (sb_q.size() != 0)
      check("scoreboard drained", 8'(sb_q.size()), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
